// File: rtl/uart_transceiver_if.sv
// Byte-side and serial-side signals of the UART transceiver.
// The slave modport is the transceiver; the master modport is whoever drives it.
interface uart_transceiver_if;
    logic       rx;
    logic [7:0] data_out;
    logic       done;
    logic [7:0] data_in;
    logic       start;
    logic       busy;
    logic       tx;

    modport master (output rx, data_in, start, input data_out, done, busy, tx);
    modport slave  (input rx, data_in, start, output data_out, done, busy, tx);
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent receiver and transmitter sharing clock, reset and baud.
// Each bit lasts CLK_FREQ/BAUD_RATE clocks; that ratio must be at least 4.
module uart_transceiver #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_transceiver_if.slave bus
);
    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    state_t           rx_state, rx_state_next;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_next;
    logic [2:0]       rx_idx, rx_idx_next;
    logic [7:0]       rx_shift, rx_shift_next;
    logic [7:0]       rx_data, rx_data_next;
    logic             rx_done, rx_done_next;

    state_t           tx_state, tx_state_next;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_next;
    logic [2:0]       tx_idx, tx_idx_next;
    logic [7:0]       tx_data, tx_data_next;
    logic             tx_line, tx_line_next;
    logic             tx_busy, tx_busy_next;

    assign bus.data_out = rx_data;
    assign bus.done     = rx_done;
    assign bus.tx       = tx_line;
    assign bus.busy     = tx_busy;

    // rx_prev lags the synchronized line by one cycle so IDLE can spot a high-to-low edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_idx   <= rx_idx_next;
            rx_shift <= rx_shift_next;
            rx_data  <= rx_data_next;
            rx_done  <= rx_done_next;
        end
    end

    // Samples are shifted in from the top, so after eight bits the first one sits in bit 0.
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt + CNT_ONE;
        rx_idx_next   = rx_idx;
        rx_shift_next = rx_shift;
        rx_data_next  = rx_data;
        rx_done_next  = 1'b0;
        unique case (rx_state)
            IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev && !rx_sync) begin
                    rx_state_next = START;
                end
            end
            START: begin
                if (rx_cnt == HALF_BIT) begin
                    rx_cnt_next   = '0;
                    rx_idx_next   = '0;
                    rx_state_next = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    rx_idx_next   = rx_idx + 3'd1;
                    if (rx_idx == 3'd7) begin
                        rx_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_next   = '0;
                    rx_state_next = IDLE;
                    if (rx_sync) begin
                        rx_data_next = rx_shift;
                        rx_done_next = 1'b1;
                    end
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_data  <= '0;
            tx_line  <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_idx   <= tx_idx_next;
            tx_data  <= tx_data_next;
            tx_line  <= tx_line_next;
            tx_busy  <= tx_busy_next;
        end
    end

    // tx and busy are decoded from the next state and registered, so the pin never glitches.
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt + CNT_ONE;
        tx_idx_next   = tx_idx;
        tx_data_next  = tx_data;
        tx_line_next  = 1'b1;
        unique case (tx_state)
            IDLE: begin
                tx_cnt_next = '0;
                tx_idx_next = '0;
                if (bus.start) begin
                    tx_data_next  = bus.data_in;
                    tx_state_next = START;
                end
            end
            START: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_next   = '0;
                    tx_state_next = DATA;
                end
            end
            DATA: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_next = '0;
                    tx_idx_next = tx_idx + 3'd1;
                    if (tx_idx == 3'd7) begin
                        tx_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_next   = '0;
                    tx_state_next = IDLE;
                end
            end
            default: tx_state_next = IDLE;
        endcase
        case (tx_state_next)
            START:   tx_line_next = 1'b0;
            DATA:    tx_line_next = tx_data_next[tx_idx_next];
            default: tx_line_next = 1'b1;
        endcase
        tx_busy_next = (tx_state_next != IDLE);
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench: instance a loops tx back to rx at the default baud, instance b runs
// at 10 clocks per bit with rx driven by the bench and tx checked bit by bit.
module tb_uart_transceiver;
    localparam int FAST_CLK  = 1_000_000;
    localparam int FAST_BAUD = 100_000;
    localparam int FAST_CPB  = FAST_CLK / FAST_BAUD;
    localparam int SLOW_CPB  = 50_000_000 / 115200;
    localparam int LAT_MIN   = 9 * SLOW_CPB + SLOW_CPB / 2;
    localparam int LAT_MAX   = LAT_MIN + 8;

    typedef struct {
        logic [7:0]  data;
        int unsigned sent_cycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n_a;
    logic        reset_n_b;
    int unsigned cycle_count = 0;

    int checks   = 0;
    int failures = 0;

    exp_t       queue_a[$];
    logic [7:0] queue_b[$];
    exp_t       popped_a;
    logic [7:0] popped_b;
    int         done_count_a = 0;
    int         done_count_b = 0;
    logic       prev_done_a  = 1'b0;
    logic       prev_done_b  = 1'b0;
    logic [7:0] last_good_b  = 8'h00;

    uart_transceiver_if bus_a ();
    uart_transceiver_if bus_b ();

    assign bus_a.rx = bus_a.tx;

    uart_transceiver dut_a (
        .clk     (clk),
        .reset_n (reset_n_a),
        .bus     (bus_a)
    );

    uart_transceiver #(
        .CLK_FREQ  (FAST_CLK),
        .BAUD_RATE (FAST_BAUD)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n_b),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Loopback monitor: every done must match the oldest byte sent and arrive on time.
    always @(negedge clk) begin
        if (reset_n_a && bus_a.done) begin
            done_count_a++;
            check_output("a_done_single_cycle", prev_done_a, 1'b0);
            check_output("a_done_expected", queue_a.size() > 0, 1'b1);
            if (queue_a.size() > 0) begin
                popped_a = queue_a.pop_front();
                check_output("a_data_out", bus_a.data_out, popped_a.data);
                check_range("a_latency", int'(cycle_count - popped_a.sent_cycle), LAT_MIN, LAT_MAX);
            end
        end
        prev_done_a = bus_a.done;
    end

    always @(negedge clk) begin
        if (reset_n_b && bus_b.done) begin
            done_count_b++;
            check_output("b_done_single_cycle", prev_done_b, 1'b0);
            check_output("b_done_expected", queue_b.size() > 0, 1'b1);
            if (queue_b.size() > 0) begin
                popped_b = queue_b.pop_front();
                check_output("b_data_out", bus_b.data_out, popped_b);
            end
        end
        prev_done_b = bus_b.done;
    end

    // Drives one frame on instance b's rx; only a frame with a good stop bit is expected back.
    task automatic apply_stimulus(input logic [7:0] value, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, value, 1'b0};
        if (stop_bit) begin
            queue_b.push_back(value);
            last_good_b = value;
        end
        for (int k = 0; k < 10; k++) begin
            bus_b.rx = frame[k];
            repeat (FAST_CPB) @(posedge clk);
            #1;
        end
        bus_b.rx = 1'b1;
        repeat (2 * FAST_CPB) @(posedge clk);
        #1;
    endtask

    // Sends one byte on instance b and checks each bit centre; a second start mid-frame must be ignored.
    task automatic check_tx_frame(input logic [7:0] value);
        logic [9:0] frame;
        int         busy_cycles;
        frame       = {1'b1, value, 1'b0};
        busy_cycles = 0;
        bus_b.data_in = value;
        bus_b.start   = 1'b1;
        @(posedge clk);
        #1;
        bus_b.start = 1'b0;
        for (int c = 0; c < 12 * FAST_CPB; c++) begin
            @(negedge clk);
            if (bus_b.busy) busy_cycles++;
            if (c < 10 * FAST_CPB && (c % FAST_CPB) == FAST_CPB / 2)
                check_output($sformatf("b_tx_bit%0d_of_%02h", c / FAST_CPB, value),
                             bus_b.tx, frame[c / FAST_CPB]);
            if (c == 3 * FAST_CPB) begin
                bus_b.data_in = ~value;
                bus_b.start   = 1'b1;
            end
            if (c == 3 * FAST_CPB + 1) bus_b.start = 1'b0;
        end
        check_output("b_busy_cycles", busy_cycles, 10 * FAST_CPB);
        check_output("b_tx_idle_after_frame", bus_b.tx, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Queues a loopback byte; start stays high so it is taken in the first idle cycle.
    task automatic send_loopback(input logic [7:0] value);
        int budget;
        budget = 0;
        bus_a.data_in = value;
        bus_a.start   = 1'b1;
        while (bus_a.busy && budget < 12 * SLOW_CPB) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_output("a_tx_idle_wait", bus_a.busy, 1'b0);
        @(posedge clk);
        #1;
        check_output("a_tx_accept", bus_a.busy, 1'b1);
        queue_a.push_back('{data: value, sent_cycle: cycle_count});
    endtask

    task automatic drain_loopback();
        int budget;
        budget = 0;
        bus_a.start = 1'b0;
        while (queue_a.size() > 0 && budget < 12 * SLOW_CPB) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_output("a_drain", queue_a.size(), 0);
    endtask

    initial begin
        int         base_a;
        int         base_b;
        logic [9:0] frame;
        logic [7:0] value;
        logic       stop_bit;

        reset_n_a     = 1'b0;
        reset_n_b     = 1'b0;
        bus_a.start   = 1'b0;
        bus_a.data_in = 8'h00;
        bus_b.start   = 1'b0;
        bus_b.data_in = 8'h00;
        bus_b.rx      = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_output("a_reset_tx", bus_a.tx, 1'b1);
        check_output("a_reset_busy", bus_a.busy, 1'b0);
        check_output("a_reset_done", bus_a.done, 1'b0);
        check_output("a_reset_data_out", bus_a.data_out, 8'h00);
        check_output("b_reset_tx", bus_b.tx, 1'b1);
        check_output("b_reset_busy", bus_b.busy, 1'b0);
        check_output("b_reset_done", bus_b.done, 1'b0);
        check_output("b_reset_data_out", bus_b.data_out, 8'h00);
        reset_n_a = 1'b1;
        reset_n_b = 1'b1;

        repeat (20 * SLOW_CPB) @(posedge clk);
        #1;
        check_output("a_idle_no_done", done_count_a, 0);
        check_output("b_idle_no_done", done_count_b, 0);

        $display("[TB] transmit waveform at 10 clocks per bit");
        check_tx_frame(8'hA5);

        $display("[TB] loopback back-to-back bytes");
        base_a = done_count_a;
        send_loopback(8'h55);
        send_loopback(8'hAA);
        send_loopback(8'h00);
        send_loopback(8'hFF);
        drain_loopback();
        check_output("a_four_done_pulses", done_count_a - base_a, 4);

        $display("[TB] framing error followed by a good frame");
        base_b = done_count_b;
        apply_stimulus(8'h3C, 1'b0);
        check_output("b_framing_no_done", done_count_b - base_b, 0);
        check_output("b_framing_data_kept", bus_b.data_out, last_good_b);
        apply_stimulus(8'h81, 1'b1);
        check_output("b_after_framing_done", done_count_b - base_b, 1);
        check_output("b_after_framing_data", bus_b.data_out, 8'h81);

        $display("[TB] start-bit glitch");
        base_b = done_count_b;
        bus_b.rx = 1'b0;
        repeat (FAST_CPB / 4) @(posedge clk);
        #1;
        bus_b.rx = 1'b1;
        repeat (3 * FAST_CPB) @(posedge clk);
        #1;
        check_output("b_glitch_no_done", done_count_b - base_b, 0);
        apply_stimulus(8'h12, 1'b1);
        check_output("b_after_glitch_done", done_count_b - base_b, 1);
        check_output("b_after_glitch_data", bus_b.data_out, 8'h12);

        $display("[TB] reset in the middle of both frames");
        base_b = done_count_b;
        frame  = {1'b1, 8'h5A, 1'b0};
        bus_b.data_in = 8'hC3;
        bus_b.start   = 1'b1;
        @(posedge clk);
        #1;
        bus_b.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus_b.rx = frame[k];
            repeat (FAST_CPB) @(posedge clk);
            #1;
        end
        check_output("b_busy_before_reset", bus_b.busy, 1'b1);
        #2;
        reset_n_b = 1'b0;
        #1;
        check_output("b_mid_reset_tx", bus_b.tx, 1'b1);
        check_output("b_mid_reset_busy", bus_b.busy, 1'b0);
        check_output("b_mid_reset_done", bus_b.done, 1'b0);
        bus_b.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n_b = 1'b1;
        repeat (10 * FAST_CPB) @(posedge clk);
        #1;
        check_output("b_aborted_no_done", done_count_b - base_b, 0);
        fork
            check_tx_frame(8'h7E);
            apply_stimulus(8'h7E, 1'b1);
        join
        check_output("b_after_reset_data", bus_b.data_out, 8'h7E);

        $display("[TB] random frames");
        for (int i = 0; i < 8; i++) begin
            value    = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            apply_stimulus(value, stop_bit);
            check_output($sformatf("b_random_data_out_%0d", i), bus_b.data_out, last_good_b);
        end
        for (int i = 0; i < 3; i++) begin
            check_tx_frame(8'($urandom));
        end
        base_a = done_count_a;
        send_loopback(8'($urandom));
        send_loopback(8'($urandom));
        drain_loopback();
        check_output("a_random_done_pulses", done_count_a - base_a, 2);

        repeat (2 * FAST_CPB) @(posedge clk);
        #1;
        check_output("a_queue_empty", queue_a.size(), 0);
        check_output("b_queue_empty", queue_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
